stage1_if: RTL and testbench
============================

STAGE1_IF -- requirements
Module: stage1_IF

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 resetn  in  1  synchronous, active-low reset.
REQ-003 ds_allow_in  in  1  decode stage can accept an instruction this cycle.
REQ-004 fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
REQ-005 fs_to_ds_bus  out  64  {inst[63:32], pc[31:0]}.
REQ-006 br_bus  in  34  {br_cancel[33], br_taken[32], br_target[31:0]}; only br_cancel redirects, br_taken is ignored.
REQ-007 inst_sram_req  out  1  read request to instruction memory.
REQ-008 inst_sram_wr / inst_sram_wstrb / inst_sram_wdata  out  1/4/32  tied to 0.
REQ-009 inst_sram_size  out  2  tied to 2'b10 (word).
REQ-010 inst_sram_addr  out  32  request address, equal to nextpc.
REQ-011 inst_sram_addr_ok  in  1  request accepted this cycle (req & addr_ok = address handshake).
REQ-012 inst_sram_data_ok  in  1  read data returned this cycle.
REQ-013 inst_sram_rdata  in  32  returned instruction word.

Function
REQ-014 FSM states: IDLE (may request), WAIT (one request outstanding), HOLD (instruction buffered for decode); at most one outstanding request.
REQ-015 inst_sram_req = 1 only in IDLE and only while resetn = 1.
REQ-016 nextpc priority: br_target if br_cancel = 1 this cycle; else buffered target if br_buf_valid; else fs_pc + 4 (32-bit wrap, no overflow check).
REQ-017 IDLE & req & addr_ok: fs_pc <= nextpc, clear br_buf_valid, go to WAIT.
REQ-018 WAIT & data_ok & !discard: inst_buf <= rdata, go to HOLD; latency: fs_to_ds_valid asserts the cycle after data_ok.
REQ-019 HOLD: fs_to_ds_valid = 1, fs_to_ds_bus = {inst_buf, fs_pc}; stays stable until accepted.
REQ-020 HOLD & ds_allow_in & !br_cancel: transfer complete, go to IDLE.
REQ-021 br_cancel in IDLE without address handshake that cycle: br_buf_valid <= 1, br_buf_target <= br_target.
REQ-022 br_cancel in IDLE with handshake that cycle: request uses br_target; br_buf_valid stays/clears to 0.
REQ-023 br_cancel in WAIT, no data_ok: set discard, buffer target, stay WAIT.
REQ-024 WAIT & data_ok & discard: drop data, clear discard, go to IDLE.
REQ-025 br_cancel in WAIT with data_ok the same cycle: drop data, buffer target, go to IDLE; discard stays 0.
REQ-026 br_cancel in HOLD: drop the held instruction regardless of ds_allow_in, buffer target, go to IDLE; fs_to_ds_valid is 0 from the next cycle.
REQ-027 A later br_cancel overwrites br_buf_target.
REQ-028 Misaligned br_target is fetched unchanged; this block raises no exceptions.
REQ-029 data_ok in IDLE or HOLD is ignored.

Reset
REQ-030 While resetn = 0: state = IDLE, fs_pc = 32'h1BFF_FFFC, br_buf_valid = 0, discard = 0, inst_buf = 0, fs_to_ds_valid = 0, inst_sram_req = 0.
REQ-031 First request after reset: cycle after resetn rises, addr = 32'h1C00_0000.
REQ-032 Reset mid-operation abandons any outstanding request.
REQ-033 Instruction memory is reset with the core, so no pre-reset data_ok arrives.

Structure
REQ-034 Shared header holds WIDTH_FS_TO_DS_BUS = 64, WIDTH_BR_BUS = 34 (corrected from 33), and the reset PC constant; decode uses the same header.
REQ-035 State encoding is a localparam inside the module.
REQ-036 No sub-module; FSM, PC, branch buffer and inst buffer are inline.

Verification
REQ-037 Reset release, 1-cycle memory, ds_allow_in = 1 -> addresses 1C000000, 1C000004, 1C000008 issued every 3 cycles; bus pc fields match.
REQ-038 ds_allow_in = 0 for 5 cycles while in HOLD -> fs_to_ds_valid and bus stay constant, no new req; accepted the cycle ds_allow_in rises.
REQ-039 br_cancel, target 1C000100, during WAIT with data_ok delayed 3 cycles -> that data never reaches decode; next request addr = 1C000100.
REQ-040 br_cancel, target 1C000200, in HOLD with ds_allow_in = 1 -> instruction not counted as transferred; next addr = 1C000200.
REQ-041 br_cancel, target 1C000300, in IDLE with addr_ok = 0 for 2 cycles -> request held at 1C000300 until addr_ok, then fs_pc = 1C000300.
REQ-042 resetn low for 1 cycle during WAIT -> req = 0 that cycle; next request addr = 1C000000, discard = 0.

Source files
------------

// File: rtl/stage1_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stage1_if_pkg
//  Description : Shared widths and constants for the fetch/decode interface.
//                Decode imports the same package so the bus widths agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package stage1_if_pkg;

  // {inst[63:32], pc[31:0]}
  localparam int WIDTH_FS_TO_DS_BUS = 64;

  // {br_cancel[33], br_taken[32], br_target[31:0]}
  localparam int WIDTH_BR_BUS = 34;

  // Chosen so that the first sequential fetch (RESET_PC + 4) lands on 1C00_0000
  localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

endpackage : stage1_if_pkg
`default_nettype wire

// File: rtl/stage1_if.sv
`default_nettype none
// ============================================================================
//  Module      : stage1_if
//  Description : Instruction fetch stage. Issues one word read at a time to
//                the instruction SRAM, buffers the returned word for decode,
//                and redirects on br_cancel (dropping any wrong-path fetch).
//  Revision    : 1.0 - initial release
// ============================================================================
module stage1_if
  import stage1_if_pkg::*;
(
  input  logic                          clk,
  input  logic                          resetn,
  // decode handshake
  input  logic                          ds_allow_in,
  output logic                          fs_to_ds_valid,
  output logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus,
  // branch redirect
  input  logic [WIDTH_BR_BUS-1:0]       br_bus,
  // instruction SRAM
  output logic                          inst_sram_req,
  output logic                          inst_sram_wr,
  output logic [1:0]                    inst_sram_size,
  output logic [3:0]                    inst_sram_wstrb,
  output logic [31:0]                   inst_sram_addr,
  output logic [31:0]                   inst_sram_wdata,
  input  logic                          inst_sram_addr_ok,
  input  logic                          inst_sram_data_ok,
  input  logic [31:0]                   inst_sram_rdata
);

  // IDLE: free to request; WAIT: one read outstanding; HOLD: word held for decode
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        br_buf_valid_q, br_buf_valid_d;
  logic [31:0] br_buf_target_q, br_buf_target_d;
  logic        discard_q, discard_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        br_cancel;
  logic [31:0] br_target;
  logic        unused_br_taken;
  logic [31:0] nextpc;
  logic        addr_hs;

  // Only br_cancel redirects; br_taken is carried on the bus but not needed here
  assign br_cancel       = br_bus[33];
  assign unused_br_taken = br_bus[32];
  assign br_target       = br_bus[31:0];

  // A live redirect beats a buffered one, which beats sequential fetch
  assign nextpc = br_cancel      ? br_target :
                  br_buf_valid_q ? br_buf_target_q :
                                   fs_pc_q + 32'd4;

  assign inst_sram_req   = (state_q == ST_IDLE) && resetn;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign addr_hs         = inst_sram_req && inst_sram_addr_ok;

  // Gated with resetn so decode never sees a stale word while reset is held
  assign fs_to_ds_valid  = (state_q == ST_HOLD) && resetn;
  assign fs_to_ds_bus    = {inst_buf_q, fs_pc_q};

  // State register and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      fs_pc_q         <= RESET_PC;
      br_buf_valid_q  <= 1'b0;
      br_buf_target_q <= 32'd0;
      discard_q       <= 1'b0;
      inst_buf_q      <= 32'd0;
    end else begin
      state_q         <= state_d;
      fs_pc_q         <= fs_pc_d;
      br_buf_valid_q  <= br_buf_valid_d;
      br_buf_target_q <= br_buf_target_d;
      discard_q       <= discard_d;
      inst_buf_q      <= inst_buf_d;
    end
  end

  // Next-state logic: fetch FSM, redirect buffering and wrong-path discard
  always_comb begin
    state_d         = state_q;
    fs_pc_d         = fs_pc_q;
    br_buf_valid_d  = br_buf_valid_q;
    br_buf_target_d = br_buf_target_q;
    discard_d       = discard_q;
    inst_buf_d      = inst_buf_q;

    case (state_q)
      ST_IDLE: begin
        if (addr_hs) begin
          // nextpc already folds in any redirect, so the buffer is consumed
          fs_pc_d        = nextpc;
          br_buf_valid_d = 1'b0;
          state_d        = ST_WAIT;
        end else if (br_cancel) begin
          br_buf_valid_d  = 1'b1;
          br_buf_target_d = br_target;
        end
      end

      ST_WAIT: begin
        if (br_cancel) begin
          br_buf_valid_d  = 1'b1;
          br_buf_target_d = br_target;
          if (inst_sram_data_ok) begin
            // Wrong-path data arrives with the cancel: drop it right away
            discard_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            // Data still in flight: remember to drop it when it lands
            discard_d = 1'b1;
          end
        end else if (inst_sram_data_ok) begin
          discard_d = 1'b0;
          if (discard_q) begin
            state_d = ST_IDLE;
          end else begin
            inst_buf_d = inst_sram_rdata;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (br_cancel) begin
          // Held word is wrong-path even if decode would take it this cycle
          br_buf_valid_d  = 1'b1;
          br_buf_target_d = br_target;
          state_d         = ST_IDLE;
        end else if (ds_allow_in) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule : stage1_if
`default_nettype wire

// File: tb/tb_stage1_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage1_if
//  Description : Self-checking bench for stage1_if. A transaction-level model
//                tracks the memory's outstanding read, the word waiting for
//                decode and any pending redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage1_if;
  import stage1_if_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic [33:0] br_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;          // address of the most recently issued fetch
  bit          m_pend;        // a redirect is waiting for the next fetch
  logic [31:0] m_pend_tgt;
  bit          m_busy;        // memory owes us a read response
  bit          m_killed;      // that response belongs to a cancelled path
  int          m_cnt;         // cycles until the memory answers
  logic [31:0] m_data;        // word the memory will return
  bit          m_held;        // a word is waiting for decode
  logic [31:0] m_held_pc;
  logic [31:0] m_held_inst;
  int          transfers = 0;

  always #5 clk = ~clk;

  stage1_if dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allow_in       (ds_allow_in),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .br_bus            (br_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  // lat = cycles from address handshake to data_ok if a fetch is issued now;
  // spur = raise data_ok while nothing is outstanding (must be ignored).
  task automatic step(input bit rn, input bit allow, input bit aok, input bit cancel,
                      input logic [31:0] tgt, input int lat, input bit spur);
    bit          exp_req;
    bit          dok;
    logic [31:0] exp_addr;
    logic [31:0] rdat;

    dok  = rn && ((m_busy && m_cnt == 0) || (!m_busy && spur));
    rdat = (m_busy && m_cnt == 0) ? m_data : 32'($urandom);
    resetn            = rn;
    ds_allow_in       = allow;
    inst_sram_addr_ok = aok;
    br_bus            = {cancel, 1'($urandom), tgt};
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rdat;
    #1;

    exp_req  = rn && !m_busy && !m_held;
    exp_addr = cancel ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
    chk("req", 64'(inst_sram_req), 64'(exp_req));
    if (exp_req) chk("addr", 64'(inst_sram_addr), 64'(exp_addr));
    chk("valid", 64'(fs_to_ds_valid), 64'(rn && m_held));
    if (rn && m_held) chk("bus", fs_to_ds_bus, {m_held_inst, m_held_pc});
    chk("tieoff", 64'({inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, inst_sram_size}),
        64'({1'b0, 4'b0000, 32'd0, 2'b10}));

    if (!rn) begin
      m_pc = RESET_PC; m_pend = 0; m_busy = 0; m_killed = 0; m_held = 0;
    end else if (m_held) begin
      if (cancel) begin
        m_held = 0; m_pend = 1; m_pend_tgt = tgt;
      end else if (allow) begin
        m_held = 0; transfers++;
      end
    end else if (m_busy) begin
      if (dok) begin
        m_busy = 0;
        if (cancel) begin
          m_pend = 1; m_pend_tgt = tgt;
        end else if (!m_killed) begin
          m_held = 1; m_held_pc = m_pc; m_held_inst = rdat;
        end
        m_killed = 0;
      end else begin
        m_cnt--;
        if (cancel) begin
          m_killed = 1; m_pend = 1; m_pend_tgt = tgt;
        end
      end
    end else if (exp_req && aok) begin
      m_pc = exp_addr; m_pend = 0;
      m_busy = 1; m_killed = 0; m_cnt = lat - 1; m_data = $urandom;
    end else if (cancel) begin
      m_pend = 1; m_pend_tgt = tgt;
    end

    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; ds_allow_in = 1'b0; br_bus = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    m_pc = RESET_PC; m_pend = 0; m_pend_tgt = '0; m_busy = 0; m_killed = 0;
    m_cnt = 0; m_data = '0; m_held = 0; m_held_pc = '0; m_held_inst = '0;
    @(negedge clk);

    // Reset, then back-to-back fetches with a 1-cycle memory
    repeat (3) step(0, 1, 1, 0, 32'd0, 1, 0);
    chk("first_addr", 64'(inst_sram_addr), 64'(32'h1C00_0000));
    repeat (9) step(1, 1, 1, 0, 32'd0, 1, 0);

    // Decode stalls for 5 cycles while a word is held
    step(1, 1, 1, 0, 32'd0, 1, 0);
    step(1, 1, 1, 0, 32'd0, 1, 0);
    repeat (5) step(1, 0, 1, 0, 32'd0, 1, 0);
    step(1, 1, 1, 0, 32'd0, 1, 0);

    // Cancel during WAIT with data returning 3 cycles later
    step(1, 1, 1, 0, 32'd0, 4, 0);
    step(1, 1, 1, 1, 32'h1C00_0100, 1, 0);
    repeat (3) step(1, 1, 1, 0, 32'd0, 1, 0);
    chk("redirect_wait", 64'(inst_sram_addr), 64'(32'h1C00_0100));
    step(1, 1, 1, 0, 32'd0, 1, 0);
    step(1, 1, 1, 0, 32'd0, 1, 0);

    // Cancel in HOLD while decode is ready
    step(1, 1, 1, 1, 32'h1C00_0200, 1, 0);
    chk("redirect_hold", 64'(inst_sram_addr), 64'(32'h1C00_0200));
    repeat (3) step(1, 1, 1, 0, 32'd0, 1, 0);

    // Cancel in IDLE while the memory refuses the address
    step(1, 1, 0, 1, 32'h1C00_0300, 1, 0);
    step(1, 1, 0, 0, 32'd0, 1, 0);
    step(1, 1, 1, 0, 32'd0, 1, 0);
    step(1, 1, 1, 0, 32'd0, 1, 0);
    chk("pc_after_idle_redirect", 64'(fs_to_ds_bus[31:0]), 64'(32'h1C00_0300));
    step(1, 1, 1, 0, 32'd0, 1, 0);

    // One-cycle reset while a read is outstanding
    step(1, 1, 1, 0, 32'd0, 3, 0);
    step(0, 1, 1, 0, 32'd0, 1, 0);
    chk("addr_after_reset", 64'(inst_sram_addr), 64'(32'h1C00_0000));
    repeat (4) step(1, 1, 1, 0, 32'd0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                         : 32'h1C00_0000 + 32'($urandom_range(0, 255) << 2);
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0,
           tgt,
           $urandom_range(1, 4),
           $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stage1_if
`default_nettype wire
